mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_unit.sv | 212 +++++++++++++++++++++
 tb/tb_mul_div_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// ============================================================================
// Module      : mul_div_unit
// Description : Iterative RV32M multiply/divide unit with fixed 34-cycle latency.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mul_div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [4:0]      rd_addr,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out,
    output logic            we_out
);

    localparam int          CW         = $clog2(XLEN);
    localparam logic [CW-1:0] C_CNT_LAST = CW'(XLEN - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PREP = 3'd1;
    localparam logic [2:0] S_CALC = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [2:0] C_F_MUL    = 3'b000;
    localparam logic [2:0] C_F_MULH   = 3'b001;
    localparam logic [2:0] C_F_MULHSU = 3'b010;
    localparam logic [2:0] C_F_MULHU  = 3'b011;
    localparam logic [2:0] C_F_DIV    = 3'b100;
    localparam logic [2:0] C_F_DIVU   = 3'b101;
    localparam logic [2:0] C_F_REM    = 3'b110;
    localparam logic [2:0] C_F_REMU   = 3'b111;

    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic [CW-1:0]     r_cnt;
    logic [2:0]        r_f3;
    logic [XLEN-1:0]   r_a;
    logic [XLEN-1:0]   r_b;
    logic [4:0]        r_rd;
    logic              r_neg_a;
    logic              r_neg_b;
    logic [XLEN-1:0]   r_opnd;
    logic [XLEN-1:0]   r_hi;
    logic [XLEN-1:0]   r_lo;
    logic [XLEN-1:0]   r_result;
    logic [4:0]        r_rd_out;

    logic              w_accept;
    logic              w_is_div;
    logic              w_sgn_a;
    logic              w_sgn_b;
    logic              w_neg_a;
    logic              w_neg_b;
    logic [XLEN-1:0]   w_mag_a;
    logic [XLEN-1:0]   w_mag_b;
    logic [XLEN:0]     w_mul_sum;
    logic [XLEN:0]     w_div_shift;
    logic [XLEN:0]     w_div_diff;
    logic              w_div_ok;
    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_quo_fix;
    logic [XLEN-1:0]   w_rem_fix;
    logic              w_div0;
    logic [XLEN-1:0]   w_fix_result;

    assign w_accept = start && !kill && (r_state == S_IDLE || r_state == S_DONE);
    assign w_is_div = r_f3[2];

    // Operand signedness follows the latched opcode, so PREP sees stable values.
    assign w_sgn_a = (r_f3 == C_F_MULH) || (r_f3 == C_F_MULHSU) ||
                     (r_f3 == C_F_DIV)  || (r_f3 == C_F_REM);
    assign w_sgn_b = (r_f3 == C_F_MULH) || (r_f3 == C_F_DIV) || (r_f3 == C_F_REM);
    assign w_neg_a = w_sgn_a && r_a[XLEN-1];
    assign w_neg_b = w_sgn_b && r_b[XLEN-1];
    assign w_mag_a = w_neg_a ? -r_a : r_a;
    assign w_mag_b = w_neg_b ? -r_b : r_b;

    // Multiply: conditional add of the multiplicand, then shift {hi,lo} right.
    assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);

    // Divide: restoring step; the partial remainder is always below the divisor,
    // so bit XLEN of the difference is a clean borrow flag.
    assign w_div_shift = {r_hi, r_lo[XLEN-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_opnd};
    assign w_div_ok    = !w_div_diff[XLEN];

    assign w_prod     = {r_hi, r_lo};
    assign w_prod_fix = (r_neg_a ^ r_neg_b) ? -w_prod : w_prod;
    assign w_quo_fix  = (r_neg_a ^ r_neg_b) ? -r_lo : r_lo;
    assign w_rem_fix  = r_neg_a ? -r_hi : r_hi;
    assign w_div0     = (r_b == '0);

    always_comb begin
        w_fix_result = '0;
        case (r_f3)
            C_F_MUL:    w_fix_result = w_prod_fix[XLEN-1:0];
            C_F_MULH,
            C_F_MULHSU,
            C_F_MULHU:  w_fix_result = w_prod_fix[2*XLEN-1:XLEN];
            C_F_DIV,
            C_F_DIVU:   w_fix_result = w_div0 ? '1 : w_quo_fix;
            C_F_REM,
            C_F_REMU:   w_fix_result = w_div0 ? r_a : w_rem_fix;
            default:    w_fix_result = '0;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; kill overrides every transition
    always_comb begin
        w_next = r_state;
        if (kill) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  w_next = w_accept ? S_PREP : S_IDLE;
                S_PREP:  w_next = S_CALC;
                S_CALC:  w_next = (r_cnt == C_CNT_LAST) ? S_FIX : S_CALC;
                S_FIX:   w_next = S_DONE;
                S_DONE:  w_next = w_accept ? S_PREP : S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    // Output logic
    always_comb begin
        busy   = 1'b0;
        done   = 1'b0;
        we_out = 1'b0;
        case (r_state)
            S_PREP, S_CALC, S_FIX: busy = 1'b1;
            S_DONE: begin
                done   = 1'b1;
                we_out = (r_rd_out != 5'd0);
            end
            default: ;
        endcase
    end

    assign result = r_result;
    assign rd_out = r_rd_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_f3     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_rd     <= '0;
            r_neg_a  <= 1'b0;
            r_neg_b  <= 1'b0;
            r_opnd   <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_result <= '0;
            r_rd_out <= '0;
        end else begin
            if (w_accept) begin
                r_f3 <= funct3;
                r_a  <= rs1_val;
                r_b  <= rs2_val;
                r_rd <= rd_addr;
            end
            if (r_state == S_PREP) begin
                r_cnt   <= '0;
                r_neg_a <= w_neg_a;
                r_neg_b <= w_neg_b;
                r_hi    <= '0;
                r_opnd  <= w_is_div ? w_mag_b : w_mag_a;
                r_lo    <= w_is_div ? w_mag_a : w_mag_b;
            end
            if (r_state == S_CALC) begin
                r_cnt <= r_cnt + 1'b1;
                if (w_is_div) begin
                    r_hi <= w_div_ok ? w_div_diff[XLEN-1:0] : w_div_shift[XLEN-1:0];
                    r_lo <= {r_lo[XLEN-2:0], w_div_ok};
                end else begin
                    r_hi <= w_mul_sum[XLEN:1];
                    r_lo <= {w_mul_sum[0], r_lo[XLEN-1:1]};
                end
            end
            if (r_state == S_FIX && w_next == S_DONE) begin
                r_result <= w_fix_result;
                r_rd_out <= r_rd;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mul_div_unit.sv
// ============================================================================
// Module      : tb_mul_div_unit
// Description : Scoreboard bench for mul_div_unit using directed RV32M vectors.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        kill;
    logic [2:0]  funct3;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [4:0]  rd_addr;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;
    logic        we_out;

    mul_div_unit #(.XLEN(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .kill    (kill),
        .funct3  (funct3),
        .rs1_val (rs1_val),
        .rs2_val (rs2_val),
        .rd_addr (rd_addr),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .rd_out  (rd_out),
        .we_out  (we_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        we;
        int          acc;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, req);
    endtask

    // Monitor: every done pulse must match the oldest outstanding request
    always @(negedge clk) begin : monitor
        exp_t e;
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("result", result, e.res);
                check("rd_out", {27'd0, rd_out}, {27'd0, e.rd});
                check("we_out", {31'd0, we_out}, {31'd0, e.we});
                check("latency", 32'(cyc - e.acc), 32'd34);
            end
        end
        if (we_out === 1'b1 && done !== 1'b1) check("we_without_done", 32'd1, 32'd0);
    end

    localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
    localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

    localparam int NV = 18;
    logic [2:0]  vf [NV] = '{MUL, MULH, MULHU, MULHSU, DIV, REM, DIVU, REMU, DIV,
                            REMU, DIV, REM, DIVU, REM, DIV, REM, MUL, MULH};
    logic [31:0] va [NV] = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                            32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100, 32'd9,
                            32'd5, 32'h80000000, 32'h80000000, 32'd9, 32'hFFFFFFF9,
                            32'd7, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] vb [NV] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                            32'd2, 32'd2, 32'd7, 32'd7, 32'd0,
                            32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0,
                            32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [4:0]  vr [NV] = '{5'd5, 5'd1, 5'd2, 5'd3, 5'd4, 5'd6, 5'd7, 5'd8, 5'd9,
                            5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd0, 5'd17};
    logic [31:0] vx [NV] = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF,
                            32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2, 32'hFFFFFFFF,
                            32'd5, 32'h80000000, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFF9,
                            32'hFFFFFFFD, 32'd1, 32'd1, 32'd0};

    task automatic push_exp(input logic [4:0] rd, input logic [31:0] res);
        exp_t e;
        e.res = res;
        e.rd  = rd;
        e.we  = (rd != 5'd0);
        e.acc = cyc;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input bit push, input logic [31:0] res);
        @(negedge clk);
        start   = 1'b1;
        funct3  = f;
        rs1_val = a;
        rs2_val = b;
        rd_addr = rd;
        @(posedge clk);
        #1;
        if (push) push_exp(rd, res);
        start = 1'b0;
    endtask

    task automatic wait_done();
        bit got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (done === 1'b1) got = 1'b1;
        end
        check("done_seen", {31'd0, got}, 32'd1);
    endtask

    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] res);
        issue(f, a, b, rd, 1'b1, res);
        wait_done();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; kill = 1'b0;
        funct3 = '0; rs1_val = '0; rs2_val = '0; rd_addr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy",   {31'd0, busy},   32'd0);
        check("reset_done",   {31'd0, done},   32'd0);
        check("reset_we",     {31'd0, we_out}, 32'd0);
        check("reset_result", result,          32'd0);
        check("reset_rd_out", {27'd0, rd_out}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) do_op(vf[i], va[i], vb[i], vr[i], vx[i]);

        // A start pulse during CALC must neither disturb operands nor add a done
        issue(MUL, 32'd6, 32'd7, 5'd3, 1'b1, 32'd42);
        repeat (10) @(negedge clk);
        start = 1'b1; funct3 = DIVU; rs1_val = 32'd1000; rs2_val = 32'd3; rd_addr = 5'd20;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        repeat (40) @(negedge clk);
        check("hold_result", result, 32'd42);

        // Start held high: second request accepted in the DONE cycle
        @(negedge clk);
        start = 1'b1; funct3 = MULHU; rs1_val = 32'h00010000; rs2_val = 32'h00010000; rd_addr = 5'd4;
        @(posedge clk);
        #1;
        push_exp(5'd4, 32'd1);
        funct3 = DIVU; rs1_val = 32'd1000; rs2_val = 32'd10; rd_addr = 5'd9;
        wait_done();
        @(posedge clk);
        #1;
        push_exp(5'd9, 32'd100);
        start = 1'b0;
        wait_done();

        // Kill at CALC counter 10
        issue(MUL, 32'd5, 32'd5, 5'd7, 1'b0, 32'd0);
        repeat (11) @(posedge clk);
        @(negedge clk);
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        check("kill_busy",   {31'd0, busy}, 32'd0);
        check("kill_done",   {31'd0, done}, 32'd0);
        check("kill_result", result,        32'd100);
        check("kill_rd_out", {27'd0, rd_out}, 32'd9);
        repeat (40) @(negedge clk);
        do_op(MUL, 32'd3, 32'd4, 5'd1, 32'd12);

        // Reset at CALC counter 10
        issue(DIVU, 32'd77, 32'd5, 5'd6, 1'b0, 32'd0);
        repeat (11) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_busy",   {31'd0, busy},   32'd0);
        check("rst_done",   {31'd0, done},   32'd0);
        check("rst_result", result,          32'd0);
        check("rst_rd_out", {27'd0, rd_out}, 32'd0);
        repeat (40) @(negedge clk);
        do_op(MUL, 32'd3, 32'd4, 5'd2, 32'd12);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
